// File: rtl/stream_serializer_pkg.sv
// rtl/stream_serializer_pkg.sv - shared types and width helpers for the word-to-byte serializer
package stream_serializer_pkg;

    localparam int MAX_WORD_BYTES = 16;
    localparam int MAX_LEN_W      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Sized for the widest legal word so the FIFO and shifter share one type.
    typedef struct packed {
        logic [8*MAX_WORD_BYTES-1:0] data;
        logic [MAX_LEN_W-1:0]        len;
    } fifo_entry_t;

    function automatic int len_width(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_word_fifo.sv
// rtl/stream_word_fifo.sv - single-clock word FIFO with occupancy level
module stream_word_fifo
    import stream_serializer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fifo_entry_t      push_entry,
    input  logic             pop,
    output fifo_entry_t      pop_entry,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    fifo_entry_t      mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign pop_entry = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - buffers wide words and emits them LSB byte first on an 8-bit stream
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int WORD_BYTES = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                word_in_valid,
    output logic                                word_in_ready,
    input  logic [8*WORD_BYTES-1:0]             word_in_data,
    input  logic [len_width(WORD_BYTES)-1:0]    word_in_len,
    output logic                                stream_out_valid,
    input  logic                                stream_out_ready,
    output logic [7:0]                          stream_out_data,
    output logic                                stream_out_last,
    output logic [level_width(FIFO_DEPTH)-1:0]  fifo_level,
    output logic                                busy,
    output logic [COUNT_W-1:0]                  byte_count
);

    localparam int LEN_W = len_width(WORD_BYTES);

    state_t               state_q, state_d;
    logic [MAX_LEN_W-1:0] idx_q, idx_d;
    fifo_entry_t          shift_q, shift_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    fifo_entry_t entry_in, entry_out;
    logic        fifo_full, fifo_empty, fifo_pop, fifo_push, at_last;

    always_comb begin
        entry_in                      = '0;
        entry_in.data[8*WORD_BYTES-1:0] = word_in_data;
        entry_in.len[LEN_W-1:0]       = word_in_len;
    end

    // Ready depends only on the registered level so there is no path from stream_out_ready.
    assign word_in_ready = reset_n && !fifo_full;
    assign fifo_push     = word_in_valid && word_in_ready;

    stream_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (entry_in),
        .pop        (fifo_pop),
        .pop_entry  (entry_out),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign at_last          = (state_q == ST_SEND) && (idx_q == shift_q.len);
    assign stream_out_valid = (state_q == ST_SEND);
    assign stream_out_last  = at_last;
    assign stream_out_data  = (state_q == ST_SEND) ? shift_q.data[{idx_q, 3'b000} +: 8] : 8'h00;
    assign busy             = (state_q == ST_SEND) || !fifo_empty;
    assign byte_count       = count_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        count_d  = count_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = entry_out;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stream_out_ready) begin
                    count_d = count_q + 1'b1;
                    if (at_last) begin
                        idx_d = '0;
                        // Reload on the final byte's edge so words stream without a bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = entry_out;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule
